// File: rtl/nap_pkg.sv
// Shared types and constants for the nap timer controller.
package nap_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    AUTO_LOAD,
    ENTRY_TENS,
    ENTRY_UNITS,
    ARMED,
    COUNT,
    DONE,
    ALARM
  } nap_state_t;

  // One 6-bit display field (minutes or seconds)
  typedef logic [5:0] nap_field_t;

  // Remaining time as a minutes/seconds pair
  typedef struct packed {
    nap_field_t min;
    nap_field_t sec;
  } nap_time_t;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam nap_field_t SEC_WRAP      = 6'd59;

  // One-second decrement; saturates at 00:00 instead of wrapping
  function automatic nap_time_t nap_time_dec(input nap_time_t t);
    nap_time_t r;
    r = t;
    if (t.sec == '0) begin
      if (t.min != '0) begin
        r.min = t.min - 6'd1;
        r.sec = SEC_WRAP;
      end
    end else begin
      r.sec = t.sec - 6'd1;
    end
    return r;
  endfunction

  function automatic logic nap_time_zero(input nap_time_t t);
    return (t.min == '0) && (t.sec == '0);
  endfunction

endpackage

// File: rtl/nap_tick_gen.sv
// Seconds prescaler: counts 0..CLK_HZ-1 while running and flags the wrap
// cycle with a one-cycle tick. A clear restarts the count at zero.
module nap_tick_gen #(
  parameter int CLK_HZ = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_reg;

  // Prescaler counter: clear has priority, holds when not running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tick = run && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/nap_timer_ctrl.sv
// Nap timer controller: auto/manual nap length setting, seconds countdown,
// and alarm beeper. Optional snooze support is enabled by defining the
// macro NAP_TIMER_SNOOZE_EN.
module nap_timer_ctrl
  import nap_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int AUTO_MIN   = 20,
  parameter int MAX_MIN    = 59,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enAutoSetting,
  input  logic       enManualSetting,
  input  logic       enSleep,
  input  logic       enAlarm,
  input  logic       enCancel,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  input  logic       snooze,
  output logic       completeSetting,
  output logic       completeSleep,
  output logic       beep,
  output logic [5:0] remainMin,
  output logic [5:0] remainSec
);

  nap_state_t state_reg, state_next;
  nap_time_t  time_reg, time_next;
  logic [3:0] tens_reg, tens_next;
  logic       beep_reg, beep_next;
  logic       set_pulse_reg, set_pulse_next;
  logic       sleep_pulse_reg, sleep_pulse_next;
  logic       prescaler_clear, prescaler_run, tick;
  logic       key_digit;
  logic [6:0] entry_value;
  nap_time_t  time_dec;

`ifdef NAP_TIMER_SNOOZE_EN
  logic       snooze_reg, snooze_next;
`else
  logic       unused_snooze;
  assign unused_snooze = snooze;
`endif

  nap_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (prescaler_clear),
    .run   (prescaler_run),
    .tick  (tick)
  );

  assign key_digit   = keyValid && (keyCode <= KEY_MAX_DIGIT);
  assign entry_value = 7'(tens_reg) * 7'd10 + 7'(keyCode);
  assign time_dec    = nap_time_dec(time_reg);

  // State and datapath registers; everything the outside sees is registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      time_reg        <= '0;
      tens_reg        <= '0;
      beep_reg        <= 1'b0;
      set_pulse_reg   <= 1'b0;
      sleep_pulse_reg <= 1'b0;
`ifdef NAP_TIMER_SNOOZE_EN
      snooze_reg      <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      time_reg        <= time_next;
      tens_reg        <= tens_next;
      beep_reg        <= beep_next;
      set_pulse_reg   <= set_pulse_next;
      sleep_pulse_reg <= sleep_pulse_next;
`ifdef NAP_TIMER_SNOOZE_EN
      snooze_reg      <= snooze_next;
`endif
    end
  end

  // Next-state and datapath logic; cancel overrides everything else
  always_comb begin
    state_next       = state_reg;
    time_next        = time_reg;
    tens_next        = tens_reg;
    beep_next        = beep_reg;
    set_pulse_next   = 1'b0;
    sleep_pulse_next = 1'b0;
    prescaler_clear  = 1'b0;
    prescaler_run    = 1'b0;
`ifdef NAP_TIMER_SNOOZE_EN
    snooze_next      = snooze_reg;
`endif
    if (enCancel) begin
      state_next      = IDLE;
      time_next       = '0;
      tens_next       = '0;
      beep_next       = 1'b0;
      prescaler_clear = 1'b1;
`ifdef NAP_TIMER_SNOOZE_EN
      snooze_next     = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // Auto wins when both setting enables are high; the auto value
          // is loaded on the same edge that enters AUTO_LOAD
          if (enAutoSetting) begin
            state_next     = AUTO_LOAD;
            time_next.min  = 6'(AUTO_MIN);
            time_next.sec  = '0;
            set_pulse_next = 1'b1;
          end else if (enManualSetting) begin
            state_next = ENTRY_TENS;
          end
        end
        AUTO_LOAD: begin
          state_next = ARMED;
        end
        ENTRY_TENS: begin
          if (key_digit) begin
            tens_next  = keyCode;
            state_next = ENTRY_UNITS;
          end
        end
        ENTRY_UNITS: begin
          if (key_digit) begin
            if (entry_value == '0) begin
              state_next = ENTRY_TENS;
            end else begin
              if (entry_value > 7'(MAX_MIN)) begin
                time_next.min = 6'(MAX_MIN);
              end else begin
                time_next.min = entry_value[5:0];
              end
              time_next.sec  = '0;
              set_pulse_next = 1'b1;
              state_next     = ARMED;
            end
          end
        end
        ARMED: begin
          if (enSleep) begin
            state_next      = COUNT;
            prescaler_clear = 1'b1;
          end
        end
        COUNT: begin
          prescaler_run = 1'b1;
          if (tick) begin
            time_next = time_dec;
            if (nap_time_zero(time_dec)) begin
              sleep_pulse_next = 1'b1;
              state_next       = DONE;
            end
          end
        end
        DONE: begin
          if (enAlarm) begin
            state_next      = ALARM;
            prescaler_clear = 1'b1;
            beep_next       = 1'b1;
          end
        end
        ALARM: begin
          prescaler_run = 1'b1;
`ifdef NAP_TIMER_SNOOZE_EN
          // Snooze mutes the beeper and reuses the countdown display
          if (snooze) begin
            time_next.min   = 6'(SNOOZE_MIN);
            time_next.sec   = '0;
            beep_next       = 1'b0;
            snooze_next     = 1'b1;
            prescaler_clear = 1'b1;
          end else if (tick) begin
            if (snooze_reg) begin
              time_next = time_dec;
              if (nap_time_zero(time_dec)) begin
                snooze_next = 1'b0;
                beep_next   = 1'b1;
              end
            end else begin
              beep_next = ~beep_reg;
            end
          end
`else
          if (tick) begin
            beep_next = ~beep_reg;
          end
`endif
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign completeSetting = set_pulse_reg;
  assign completeSleep   = sleep_pulse_reg;
  assign beep            = beep_reg;
  assign remainMin       = time_reg.min;
  assign remainSec       = time_reg.sec;

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Randomized self-checking bench for nap_timer_ctrl (CLK_HZ=4). Expected
// values come from arithmetic on elapsed cycles and total seconds.
module tb_nap_timer_ctrl;

  localparam int HZ = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enAutoSetting = 1'b0, enManualSetting = 1'b0, enSleep = 1'b0;
  logic       enAlarm = 1'b0, enCancel = 1'b0, keyValid = 1'b0, snooze = 1'b0;
  logic [3:0] keyCode = 4'd0;
  logic       completeSetting, completeSleep, beep;
  logic [5:0] remainMin, remainSec;

  int total = 0;
  int bad   = 0;
  int model_secs = 0;

  nap_timer_ctrl #(
    .CLK_HZ(HZ), .AUTO_MIN(20), .MAX_MIN(59), .SNOOZE_MIN(5)
  ) dut (
    .clock(clock), .reset(reset),
    .enAutoSetting(enAutoSetting), .enManualSetting(enManualSetting),
    .enSleep(enSleep), .enAlarm(enAlarm), .enCancel(enCancel),
    .keyValid(keyValid), .keyCode(keyCode), .snooze(snooze),
    .completeSetting(completeSetting), .completeSleep(completeSleep),
    .beep(beep), .remainMin(remainMin), .remainSec(remainSec)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_time(input string tag, input int secs);
    chk({tag, "_min"}, int'(remainMin), secs / 60);
    chk({tag, "_sec"}, int'(remainSec), secs % 60);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input int code);
    keyValid = 1'b1;
    keyCode  = 4'(code);
    step();
    keyValid = 1'b0;
  endtask

  task automatic go_idle();
    enCancel = 1'b1;
    step();
    enCancel = 1'b0;
    model_secs = 0;
    chk("cancel_beep", beep, 0);
    chk("cancel_set", completeSetting, 0);
    chk_time("cancel_time", 0);
  endtask

  // Two digits with optional junk codes in between; returns via model_secs
  task automatic enter_pair(input int t, input int u);
    int v;
    if ($urandom_range(0, 1) == 1) key($urandom_range(10, 15));
    key(t);
    chk("tens_no_pulse", completeSetting, 0);
    if ($urandom_range(0, 1) == 1) begin
      key($urandom_range(10, 15));
      chk("junk_no_pulse", completeSetting, 0);
    end
    key(u);
    v = t * 10 + u;
    if (v == 0) begin
      chk("zero_no_pulse", completeSetting, 0);
    end else begin
      if (v > 59) v = 59;
      model_secs = v * 60;
      chk("manual_pulse", completeSetting, 1);
    end
    chk_time("manual_time", model_secs);
    $display("manual keys %0d %0d -> expect %0d s", t, u, model_secs);
    if (v != 0) begin
      step();
      chk("manual_pulse_end", completeSetting, 0);
    end
  endtask

  task automatic start_manual();
    enManualSetting = 1'b1;
    step();
    enManualSetting = 1'b0;
  endtask

  task automatic auto_load();
    enAutoSetting   = 1'b1;
    enManualSetting = 1'($urandom_range(0, 1));
    step();
    enAutoSetting   = 1'b0;
    enManualSetting = 1'b0;
    model_secs = 20 * 60;
    chk("auto_pulse", completeSetting, 1);
    chk_time("auto_time", model_secs);
    step();
    chk("auto_pulse_end", completeSetting, 0);
    $display("auto load -> expect %0d s", model_secs);
  endtask

  task automatic run_countdown();
    int load;
    int exp;
    load = model_secs;
    enSleep = 1'b1;
    step();
    enSleep = 1'b0;
    chk_time("sleep_start", load);
    chk("sleep_start_pulse", completeSleep, 0);
    for (int k = 1; k <= load * HZ + 3; k++) begin
      step();
      exp = load - k / HZ;
      if (exp < 0) exp = 0;
      chk_time("countdown", exp);
      chk("complete_sleep", completeSleep, (k == load * HZ) ? 1 : 0);
    end
    model_secs = 0;
    $display("countdown of %0d s checked", load);
  endtask

  task automatic run_alarm();
    int n;
    int exp_beep;
    enAlarm = 1'b1;
    step();
    enAlarm = 1'b0;
    n = $urandom_range(10, 30);
    for (int k = 0; k < n; k++) begin
      if (k > 0) step();
      chk("alarm_beep", beep, ((k / HZ) % 2 == 0) ? 1 : 0);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
`ifdef NAP_TIMER_SNOOZE_EN
    chk("snooze_beep", beep, 0);
    chk_time("snooze_time", 300);
    for (int j = 1; j <= 1200 + 10; j++) begin
      step();
      exp_beep = (j < 1200) ? 0 : ((((j - 1200) / HZ) % 2 == 0) ? 1 : 0);
      chk("snooze_beep_run", beep, exp_beep);
      chk_time("snooze_count", (300 - j / HZ < 0) ? 0 : 300 - j / HZ);
      chk("snooze_no_sleep", completeSleep, 0);
    end
    $display("alarm %0d cycles then snooze checked", n);
`else
    for (int k = n; k < n + 10; k++) begin
      if (k > n) step();
      exp_beep = ((k / HZ) % 2 == 0) ? 1 : 0;
      chk("snooze_ignored_beep", beep, exp_beep);
      chk_time("snooze_ignored_time", 0);
    end
    $display("alarm %0d cycles, snooze ignored", n);
`endif
    go_idle();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("idle_beep", beep, 0);
    end
  endtask

  task automatic cancel_in_entry();
    start_manual();
    key($urandom_range(1, 9));
    keyValid = 1'b1;
    keyCode  = 4'($urandom_range(0, 9));
    enCancel = 1'b1;
    step();
    keyValid = 1'b0;
    enCancel = 1'b0;
    chk("cancel_entry_pulse", completeSetting, 0);
    chk_time("cancel_entry_time", 0);
    key(5);
    key(5);
    chk("idle_keys_pulse", completeSetting, 0);
    chk_time("idle_keys_time", 0);
    $display("cancel during units entry checked");
  endtask

  task automatic reset_mid_count();
    auto_load();
    enSleep = 1'b1;
    step();
    enSleep = 1'b0;
    repeat ($urandom_range(5, 20)) step();
    #2 reset = 1'b0;
    #1;
    chk("rst_beep", beep, 0);
    chk("rst_set", completeSetting, 0);
    chk("rst_sleep", completeSleep, 0);
    chk_time("rst_time", 0);
    step();
    #3 reset = 1'b1;
    step();
    chk_time("rst_release_time", 0);
    repeat (8) step();
    chk_time("rst_idle_time", 0);
    $display("async reset mid-count checked");
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("init_beep", beep, 0);
    chk("init_set", completeSetting, 0);
    chk("init_sleep", completeSleep, 0);
    chk_time("init_time", 0);
    step();
    step();
    #3 reset = 1'b1;
    step();
    chk_time("post_reset_time", 0);

    for (int it = 0; it < 3; it++) begin
      auto_load();
      go_idle();
      start_manual();
      if (it == 0) begin
        enter_pair(7, 5);
        go_idle();
        start_manual();
        enter_pair(0, 0);
        enter_pair(0, 2);
      end else begin
        enter_pair($urandom_range(0, 9), $urandom_range(0, 9));
        if (model_secs == 0) enter_pair($urandom_range(0, 9), $urandom_range(1, 9));
      end
      go_idle();
      start_manual();
      enter_pair(0, $urandom_range(1, 2));
      run_countdown();
      run_alarm();
      cancel_in_entry();
    end
    reset_mid_count();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
